// File: rtl/alu_wb_regfile_if.sv
// Writeback bus from the ALU into the register file:
// result, flags, flag-update request and commit condition.
interface alu_wb_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_c;
  logic              wb_v;
  logic              wb_z;
  logic              wb_n;
  logic              wb_flag_en;
  logic [2:0]        wb_cond;

  modport master (
    output wb_valid, wb_addr, wb_data,
    output wb_c, wb_v, wb_z, wb_n,
    output wb_flag_en, wb_cond
  );

  modport slave (
    input wb_valid, wb_addr, wb_data,
    input wb_c, wb_v, wb_z, wb_n,
    input wb_flag_en, wb_cond
  );
endinterface

// File: rtl/alu_wb_regfile.sv
// RISC16 register file and writeback stage: two bypassed read
// ports, conditional commit, flag register, retire/squash counters.
module alu_wb_regfile #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  alu_wb_regfile_if.slave   wb,
  output logic [3:0]        flags,
  output logic              commit,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  squash_cnt
);

  logic [DATA_W-1:0] regs [REG_N];
  logic              pass;
  logic              take;
  logic              flag_n;
  logic              flag_z;
  logic              flag_v;
  logic              flag_c;

  assign flag_n = flags[3];
  assign flag_z = flags[2];
  assign flag_v = flags[1];
  assign flag_c = flags[0];

  // Condition sees the architectural flags, not the incoming ones.
  always_comb begin
    pass = 1'b0;
    unique case (wb.wb_cond)
      3'b000: pass = 1'b1;
      3'b001: pass = flag_z;
      3'b010: pass = ~flag_z;
      3'b011: pass = flag_c;
      3'b100: pass = ~flag_c;
      3'b101: pass = flag_n;
      3'b110: pass = flag_n ^ flag_v;
      3'b111: pass = ~(flag_n ^ flag_v);
      default: pass = 1'b0;
    endcase
  end

  assign take = wb.wb_valid & pass & ~rst;

  assign ra_data =
    (ra_addr == '0) ? '0 :
    (take && wb.wb_addr == ra_addr) ? wb.wb_data :
    regs[ra_addr];

  assign rb_data =
    (rb_addr == '0) ? '0 :
    (take && wb.wb_addr == rb_addr) ? wb.wb_data :
    regs[rb_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
      flags       <= '0;
      commit      <= 1'b0;
      commit_addr <= '0;
      retire_cnt  <= '0;
      squash_cnt  <= '0;
    end else begin
      commit <= 1'b0;
      if (take) begin
        if (wb.wb_addr != '0) begin
          regs[wb.wb_addr] <= wb.wb_data;
        end
        if (wb.wb_flag_en) begin
          flags <= {wb.wb_n, wb.wb_z, wb.wb_v, wb.wb_c};
        end
        retire_cnt  <= retire_cnt + CNT_W'(1);
        commit      <= 1'b1;
        commit_addr <= wb.wb_addr;
      end else if (wb.wb_valid) begin
        squash_cnt <= squash_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_wb_regfile.sv
// Directed bench for alu_wb_regfile: vector table for the
// writeback/condition path plus reset, same-port and wrap sequences.
module tb_alu_wb_regfile;

  logic        clk;
  logic        rst;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic [15:0] ra_data;
  logic [15:0] rb_data;
  logic [3:0]  flags;
  logic        commit;
  logic [2:0]  commit_addr;
  logic [15:0] retire_cnt;
  logic [15:0] squash_cnt;

  int checks = 0;
  int errors = 0;

  alu_wb_regfile_if #(.DATA_W(16), .ADDR_W(3)) wbi ();

  alu_wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .ra_data     (ra_data),
    .rb_data     (rb_data),
    .wb          (wbi.slave),
    .flags       (flags),
    .commit      (commit),
    .commit_addr (commit_addr),
    .retire_cnt  (retire_cnt),
    .squash_cnt  (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [3:0]  nzvc;
    logic        fen;
    logic [2:0]  cond;
    logic [2:0]  ra;
    logic [15:0] era;
    logic [2:0]  rb;
    logic [15:0] erb;
    logic [3:0]  eflags;
    logic        ecommit;
    logic [2:0]  ecaddr;
    logic [15:0] eret;
    logic [15:0] esq;
  } vec_t;

  vec_t vec [17];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] a,
                       input logic [15:0] d, input logic [3:0] nzvc,
                       input logic fen, input logic [2:0] cond);
    wbi.wb_valid   = v;
    wbi.wb_addr    = a;
    wbi.wb_data    = d;
    wbi.wb_n       = nzvc[3];
    wbi.wb_z       = nzvc[2];
    wbi.wb_v       = nzvc[1];
    wbi.wb_c       = nzvc[0];
    wbi.wb_flag_en = fen;
    wbi.wb_cond    = cond;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ret_exp;
  int          n;

  initial begin
    vec[0]  = '{1, 1, 16'h0A0A, 4'b0000, 0, 3'b000, 1, 16'h0A0A, 1, 16'h0A0A, 4'b0000, 1, 1, 16'd1, 16'd0};
    vec[1]  = '{1, 2, 16'hB0B0, 4'b0000, 0, 3'b000, 1, 16'h0A0A, 2, 16'hB0B0, 4'b0000, 1, 2, 16'd2, 16'd0};
    vec[2]  = '{1, 3, 16'hBABA, 4'b1000, 1, 3'b000, 3, 16'hBABA, 3, 16'hBABA, 4'b1000, 1, 3, 16'd3, 16'd0};
    vec[3]  = '{1, 1, 16'h8888, 4'b0000, 0, 3'b000, 1, 16'h8888, 1, 16'h8888, 4'b1000, 1, 1, 16'd4, 16'd0};
    vec[4]  = '{1, 2, 16'h1111, 4'b0000, 0, 3'b000, 2, 16'h1111, 2, 16'h1111, 4'b1000, 1, 2, 16'd5, 16'd0};
    vec[5]  = '{1, 4, 16'h7777, 4'b0011, 1, 3'b000, 4, 16'h7777, 4, 16'h7777, 4'b0011, 1, 4, 16'd6, 16'd0};
    vec[6]  = '{1, 5, 16'h5A5A, 4'b0000, 0, 3'b110, 5, 16'h5A5A, 5, 16'h5A5A, 4'b0011, 1, 5, 16'd7, 16'd0};
    vec[7]  = '{1, 5, 16'hFFFF, 4'b0000, 0, 3'b001, 5, 16'h5A5A, 5, 16'h5A5A, 4'b0011, 0, 5, 16'd7, 16'd1};
    vec[8]  = '{0, 2, 16'h1234, 4'b1111, 1, 3'b000, 2, 16'h1111, 2, 16'h1111, 4'b0011, 0, 5, 16'd7, 16'd1};
    vec[9]  = '{1, 6, 16'hBEEF, 4'b0000, 0, 3'b000, 6, 16'hBEEF, 6, 16'hBEEF, 4'b0011, 1, 6, 16'd8, 16'd1};
    vec[10] = '{1, 0, 16'h5555, 4'b0100, 1, 3'b000, 0, 16'h0000, 0, 16'h0000, 4'b0100, 1, 0, 16'd9, 16'd1};
    vec[11] = '{1, 7, 16'h7007, 4'b0000, 0, 3'b001, 7, 16'h7007, 7, 16'h7007, 4'b0100, 1, 7, 16'd10, 16'd1};
    vec[12] = '{1, 7, 16'hDEAD, 4'b0000, 0, 3'b010, 7, 16'h7007, 7, 16'h7007, 4'b0100, 0, 7, 16'd10, 16'd2};
    vec[13] = '{1, 3, 16'h0003, 4'b0001, 1, 3'b100, 3, 16'h0003, 3, 16'h0003, 4'b0001, 1, 3, 16'd11, 16'd2};
    vec[14] = '{1, 2, 16'h0022, 4'b0000, 0, 3'b011, 2, 16'h0022, 2, 16'h0022, 4'b0001, 1, 2, 16'd12, 16'd2};
    vec[15] = '{1, 1, 16'hF0F0, 4'b0000, 0, 3'b101, 1, 16'h8888, 1, 16'h8888, 4'b0001, 0, 2, 16'd12, 16'd3};
    vec[16] = '{1, 1, 16'h0111, 4'b0000, 0, 3'b111, 1, 16'h0111, 1, 16'h0111, 4'b0001, 1, 1, 16'd13, 16'd3};

    // Reset with a live request on the bus.
    rst     = 1'b1;
    ra_addr = 3'd3;
    rb_addr = 3'd3;
    drive(1, 3, 16'h1234, 4'b1111, 1, 3'b000);
    #2;
    chk("rst_ra", ra_data, 16'h0);
    chk("rst_flags", flags, 4'h0);
    chk("rst_commit", commit, 1'b0);
    chk("rst_retire", retire_cnt, 16'h0);
    chk("rst_squash", squash_cnt, 16'h0);
    tick();
    tick();
    chk("rst_hold_ra", ra_data, 16'h0);
    chk("rst_hold_commit", commit, 1'b0);
    rst = 1'b0;
    drive(0, 0, 16'h0, 4'b0000, 0, 3'b000);
    #1;
    chk("post_rst_r3", rb_data, 16'h0);
    chk("post_rst_flags", flags, 4'h0);
    chk("post_rst_retire", retire_cnt, 16'h0);

    for (int i = 0; i < 17; i++) begin
      drive(vec[i].v, vec[i].addr, vec[i].data, vec[i].nzvc,
            vec[i].fen, vec[i].cond);
      ra_addr = vec[i].ra;
      rb_addr = vec[i].rb;
      #1;
      chk($sformatf("v%0d_ra", i), ra_data, vec[i].era);
      tick();
      wbi.wb_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_rb", i), rb_data, vec[i].erb);
      chk($sformatf("v%0d_flags", i), flags, vec[i].eflags);
      chk($sformatf("v%0d_commit", i), commit, vec[i].ecommit);
      chk($sformatf("v%0d_caddr", i), commit_addr, vec[i].ecaddr);
      chk($sformatf("v%0d_retire", i), retire_cnt, vec[i].eret);
      chk($sformatf("v%0d_squash", i), squash_cnt, vec[i].esq);
    end

    // Both ports on the same address see the bypassed value.
    ra_addr = 3'd1;
    rb_addr = 3'd1;
    drive(1, 1, 16'hCAFE, 4'b0000, 0, 3'b000);
    #1;
    chk("same_ra", ra_data, 16'hCAFE);
    chk("same_rb", rb_data, 16'hCAFE);
    tick();
    wbi.wb_valid = 1'b0;
    ret_exp = 16'd14;
    chk("same_retire", retire_cnt, ret_exp);

    // Run the retire counter up to 0xFFFF, then wrap it.
    n = int'(16'hFFFF - ret_exp);
    wbi.wb_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    wbi.wb_valid = 1'b0;
    #1;
    chk("wrap_full", retire_cnt, 16'hFFFF);
    wbi.wb_valid = 1'b1;
    tick();
    wbi.wb_valid = 1'b0;
    #1;
    chk("wrap_zero", retire_cnt, 16'h0000);
    chk("wrap_commit", commit, 1'b1);

    // Reset in the middle of a pending request.
    drive(1, 5, 16'h1357, 4'b1000, 1, 3'b000);
    tick();
    chk("mid_flags_set", flags, 4'b1000);
    drive(1, 2, 16'hAAAA, 4'b0100, 1, 3'b000);
    ra_addr = 3'd2;
    rb_addr = 3'd5;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_flags", flags, 4'h0);
    chk("mid_rst_ra", ra_data, 16'h0);
    chk("mid_rst_r5", rb_data, 16'h0);
    chk("mid_rst_retire", retire_cnt, 16'h0);
    tick();
    rst = 1'b0;
    wbi.wb_valid = 1'b0;
    #1;
    chk("mid_lost_r2", ra_data, 16'h0);
    chk("mid_lost_commit", commit, 1'b0);
    drive(1, 2, 16'hAAAA, 4'b0000, 0, 3'b001);
    tick();
    wbi.wb_valid = 1'b0;
    #1;
    chk("mid_eq_squash", squash_cnt, 16'd1);
    chk("mid_eq_commit", commit, 1'b0);
    drive(1, 2, 16'hAAAA, 4'b0000, 0, 3'b010);
    tick();
    wbi.wb_valid = 1'b0;
    #1;
    chk("mid_ne_retire", retire_cnt, 16'd1);
    chk("mid_ne_r2", ra_data, 16'hAAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_wb_regfile.md
Name: alu_wb_regfile

Overview:
Register file and writeback stage for the RISC16 datapath, wrapped around the 16-bit add/sub ALU. It supplies the ALU's A/B operands from two combinational read ports. On the next clock edge it commits the ALU result S and the C/V/Z/N flags, gated by a condition code evaluated against the architectural flag register. It also provides a writeback-to-read bypass, a hardwired-zero r0, and retire/squash counters for debug.

Parameters:
DATA_W, 16, datapath width (matches ALU S/A/B)
REG_N, 8, number of registers
ADDR_W, 3, register address width (log2 REG_N)
CNT_W, 16, width of retire/squash counters

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
ra_addr  in  ADDR_W  read port A address
rb_addr  in  ADDR_W  read port B address
ra_data  out  DATA_W  operand to ALU A (combinational)
rb_data  out  DATA_W  operand to ALU B (combinational)
wb_valid  in  1  writeback request this cycle
wb_addr  in  ADDR_W  destination register
wb_data  in  DATA_W  ALU result S
wb_c, wb_v, wb_z, wb_n  in  1 each  ALU flags
wb_flag_en  in  1  request to update the flag register
wb_cond  in  3  condition code gating the commit
flags  out  4  flag register {N,Z,V,C}
commit  out  1  registered pulse: a writeback committed last edge
commit_addr  out  ADDR_W  destination of the last commit
retire_cnt  out  CNT_W  committed-writeback count
squash_cnt  out  CNT_W  condition-failed writeback count

Behaviour:
- Reset (async, rst=1):
  - all registers, flags, commit, commit_addr, retire_cnt and squash_cnt are cleared to 0 immediately.
  - ra_data and rb_data read 0.
  - wb_valid is ignored while rst=1.
- Condition pass (combinational, evaluated against the current flags, not the incoming wb flags):
  - 000 always; 001 EQ Z; 010 NE !Z; 011 CS C; 100 CC !C; 101 MI N; 110 LT N^V; 111 GE !(N^V).
- take = wb_valid & pass. On the rising edge when take=1:
  - reg[wb_addr] <= wb_data if wb_addr != 0; writes to r0 are discarded.
  - flags <= {wb_n, wb_z, wb_v, wb_c} if wb_flag_en, including when wb_addr = 0 (compare-style op).
  - retire_cnt increments by 1 (even for r0).
  - commit <= 1; commit_addr <= wb_addr.
- On an edge with wb_valid=1 and pass=0: squash_cnt increments; no register or flag change; commit <= 0.
- On an edge with wb_valid=0: commit <= 0; counters and commit_addr hold.
- Counters wrap modulo 2^CNT_W (0xFFFF + 1 -> 0x0000); no saturation.
- Read ports:
  - Address 0 always reads 0.
  - Bypass: if take=1 and wb_addr == read address != 0, the port returns wb_data in the same cycle. Otherwise it returns the stored register.
  - ra_addr == rb_addr is legal; both ports return the same value.
- Latency: writeback is visible on the read ports through the bypass in the same cycle, and from storage one cycle later. Flags and commit update one edge after the request.
- Mid-operation reset: any pending request in the reset cycle is lost; the first request after deassertion is evaluated against flags = 0.

Test Plan:
- Reset: assert rst with wb_valid=1, wb_addr=3, wb_data=0x1234 -> r3=0, flags=0, counters=0, commit=0 during and after reset.
- ALU add: r1=0x0A0A, r2=0xB0B0, ALU sum 0xBABA written to r3 with cond=000, flag_en=1 -> r3=0xBABA; flags N=1,Z=0,V=0,C=0; retire_cnt=3 after the three writes; commit=1 with commit_addr=3.
- ALU sub: r1=0x8888, r2=0x1111, result 0x7777 with C=1,V=1,N=0,Z=0 -> r4=0x7777, flags=4'b0011. A following cond=110 (LT) write to r5 commits because N^V=1.
- Squash: flags Z=0, wb_valid=1 with cond=001 (EQ), wb_addr=5, wb_data=0xFFFF -> r5 unchanged, squash_cnt increments by 1, commit=0.
- Bypass and r0: wb_addr=6, wb_data=0xBEEF, ra_addr=6 in the same cycle -> ra_data=0xBEEF immediately. A write of 0x5555 to r0 with flag_en=1 -> ra_data for address 0 stays 0 and flags update.
- Counter wrap: preload retire_cnt to 0xFFFF via 65535 commits, then commit once more -> retire_cnt=0x0000.
